// File: rtl/traceback_unit_pkg.sv
// traceback_unit_pkg: constants and FSM state encoding for the traceback unit.
// Holds trellis sizes (K=6, 32 states) and the default traceback depth.
// No ports; imported by traceback_unit and tb_ring_buf.
package traceback_unit_pkg;

  localparam int SM_WIDTH   = 8;
  localparam int STATE_W    = 5;
  localparam int N_STATES   = 32;
  localparam int TB_LEN_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACE = 2'd1,
    OUT   = 2'd2
  } tb_state_e;

endpackage

// File: rtl/tb_ring_buf.sv
// tb_ring_buf: DEPTH x WIDTH flop ring buffer holding survivor decision vectors.
// Ports: clk; wr_en/wr_addr/wr_data synchronous write port; rd_addr/rd_data combinational read.
// Contents are deliberately not reset; every entry is written before it is traced.
module tb_ring_buf
  import traceback_unit_pkg::*;
#(
  parameter int DEPTH = TB_LEN_DEF,
  parameter int WIDTH = N_STATES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/traceback_unit.sv
// traceback_unit: Viterbi survivor traceback over a TB_LEN-deep ring of decision vectors.
// Ports: clk, rst_n; step input in_valid/in_ready/dec_bits/best_state; bit output out_valid/out_ready/out_bit.
// Accept-to-out_valid TB_LEN+1 cycles; in_ready only in IDLE; out_bit held until out_ready.
// Optional macro TB_FLUSH_EN: adds input flush and emits the TB_LEN-1 trailing bits after a flushed step.
module traceback_unit
  import traceback_unit_pkg::*;
#(
  parameter int TB_LEN   = TB_LEN_DEF,
  parameter int N_STATES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_STATES-1:0] dec_bits,
  input  logic [STATE_W-1:0]  best_state,
`ifdef TB_FLUSH_EN
  input  logic                flush,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_bit
);

  localparam int PW = $clog2(TB_LEN);
  localparam int CW = $clog2(TB_LEN + 1);
  localparam logic [CW-1:0] FILL_LAST  = CW'(TB_LEN - 1);
  localparam logic [CW-1:0] FILL_MAX   = CW'(TB_LEN);
  localparam logic [PW-1:0] DEPTH_LAST = PW'(TB_LEN - 1);

  tb_state_e           state, state_nx;
  logic [PW-1:0]       wr_ptr, rd_ptr, trace_rem;
  logic [CW-1:0]       fill_cnt;
  logic [STATE_W-1:0]  cur_state;
  logic [N_STATES-1:0] rd_data;
  logic                accept, load, step, last;

`ifdef TB_FLUSH_EN
  // flush_cnt = trailing bits still to be traced; depth of the next one is flush_cnt.
  logic                flush_pend;
  logic [STATE_W-1:0]  flush_state;
  logic [PW-1:0]       flush_cnt;
  logic                relaunch, flush_done;
`endif

  tb_ring_buf #(
    .DEPTH(TB_LEN),
    .WIDTH(N_STATES)
  ) u_ring_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (dec_bits),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    accept    = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
`ifdef TB_FLUSH_EN
    relaunch   = 1'b0;
    flush_done = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          // Buffer holds TB_LEN steps once this one lands: start a full-depth trace.
          if (fill_cnt >= FILL_LAST) begin
            load     = 1'b1;
            state_nx = TRACE;
          end
        end
      end
      TRACE: begin
        step = 1'b1;
        if (trace_rem == '0) begin
          last     = 1'b1;
          state_nx = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nx = IDLE;
`ifdef TB_FLUSH_EN
          if (flush_pend) begin
            if (flush_cnt != '0) begin
              relaunch = 1'b1;
              state_nx = TRACE;
            end else begin
              flush_done = 1'b1;
            end
          end
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_cnt  <= '0;
      cur_state <= '0;
      trace_rem <= '0;
      out_bit   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_cnt != FILL_MAX) begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
      if (load) begin
        // wr_ptr still addresses the entry being written this edge.
        cur_state <= best_state;
        rd_ptr    <= wr_ptr;
        trace_rem <= DEPTH_LAST;
      end else if (step) begin
        // Predecessor state: drop the newest bit (MSB), shift in the survivor decision.
        cur_state <= {cur_state[STATE_W-2:0], rd_data[cur_state]};
        rd_ptr    <= rd_ptr - 1'b1;
        trace_rem <= trace_rem - 1'b1;
        if (last) begin
          out_bit <= cur_state[STATE_W-1];
        end
      end
`ifdef TB_FLUSH_EN
      else if (relaunch) begin
        // Newest entry is one behind wr_ptr; each trailing trace is one step shallower.
        cur_state <= flush_state;
        rd_ptr    <= wr_ptr - 1'b1;
        trace_rem <= flush_cnt - 1'b1;
      end
      if (flush_done) begin
        fill_cnt <= '0;
      end
`endif
    end
  end

`ifdef TB_FLUSH_EN
  // flush only matters on the step that launches a trace; earlier steps have no output to follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend  <= 1'b0;
      flush_state <= '0;
      flush_cnt   <= '0;
    end else if (load) begin
      flush_pend  <= flush;
      flush_state <= best_state;
      flush_cnt   <= DEPTH_LAST;
    end else if (relaunch) begin
      flush_cnt <= flush_cnt - 1'b1;
    end else if (flush_done) begin
      flush_pend <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_traceback_unit.sv
// tb_traceback_unit: scoreboard bench for traceback_unit (TB_LEN=32).
// Driver pushes expected bits as steps are issued; a negedge monitor pops on every output handshake.
// Directed checks cover reset, fill, latency, backpressure, ignored input and mid-trace reset.
module tb_traceback_unit;

  localparam int TBL = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dec_bits = '0;
  logic [4:0]  best_state = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_bit;
`ifdef TB_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int   tests = 0;
  int   fails = 0;
  logic exp_q [$];
  logic mon_exp;
  logic u [200];
  logic [4:0] st;
  logic [31:0] d;

  always #5 clk = ~clk;

  traceback_unit #(.TB_LEN(TBL), .N_STATES(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dec_bits   (dec_bits),
    .best_state (best_state),
`ifdef TB_FLUSH_EN
    .flush      (flush),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit)
  );

  // Monitor: one scoreboard entry per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_bit_unexpected: got out_bit=%0b while no output was expected", out_bit);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_bit !== mon_exp) begin
          fails++;
          $display("FAIL out_bit: got %0b expected %0b", out_bit, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] dv, input logic [4:0] bs, input bit has_exp, input logic e);
    int g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 for %0d cycles expected 1", g);
      return;
    end
    in_valid   = 1'b1;
    dec_bits   = dv;
    best_state = bs;
    if (has_exp) exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || !in_ready) && g < 400) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (exp_q.size() != 0 || !in_ready) begin
      fails++;
      $display("FAIL %s: got %0d pending outputs in_ready=%0b expected 0 pending in_ready=1",
               name, exp_q.size(), in_ready);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int g;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_bit", out_bit, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill: 31 zero steps give nothing; the 32nd decodes a 0 at cycle 33
    for (int i = 0; i < TBL - 1; i++) send('0, '0, 1'b0, 1'b0);
    check("fill_out_valid", out_valid, 0);
    check("fill_in_ready", in_ready, 1);
    send('0, '0, 1'b1, 1'b0);
    check("trace_in_ready", in_ready, 0);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, TBL + 1);
    wait_drain("drain_fill");

    // All-ones path, with a 10-cycle backpressure window on step 35
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i == 35) begin
        wait_drain("drain_before_bp");
        out_ready = 1'b0;
      end
      send(32'hFFFF_FFFF, 5'h1F, i >= TBL - 1, 1'b1);
      if (i == 35) begin
        g = 0;
        while (!out_valid && g < 60) begin
          @(negedge clk);
          g++;
        end
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("bp_out_valid", out_valid, 1);
          check("bp_out_bit", out_bit, 1);
          check("bp_in_ready", in_ready, 0);
          in_valid   = 1'b1;
          dec_bits   = '0;
          best_state = '0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_after", in_ready, 1);
      end
    end
    wait_drain("drain_ones");

    // Reference decode: ideal decisions from a K=6 shift register, output = input delayed 31
    do_reset();
    st = '0;
    for (int t = 0; t < 200; t++) begin
      logic e;
      u[t] = 1'($urandom_range(0, 1));
      d = $urandom();
      d[{u[t], st[4:1]}] = st[0];
      st = {u[t], st[4:1]};
      e = 1'b0;
      if (t >= TBL - 1) e = u[t - (TBL - 1)];
      send(d, st, t >= TBL - 1, e);
      if (t == 100) begin
        check("ignore_in_ready", in_ready, 0);
        for (int k = 0; k < 6; k++) begin
          in_valid   = 1'b1;
          dec_bits   = ~d;
          best_state = ~st;
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
    end
    wait_drain("drain_decode");

    // Reset at TRACE cycle 5 aborts the output; 31 steps then refill silently
    send($urandom(), 5'h0A, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_bit", out_bit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < TBL - 1; i++) send(32'hFFFF_FFFF, 5'h1F, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("midrst_no_output", exp_q.size(), 0);
    send(32'hFFFF_FFFF, 5'h1F, 1'b1, 1'b1);
    wait_drain("drain_after_midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation got past time limit expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
